test_status_led: RTL and testbench

- Parametrised board-test status indicator, successor to the fixed "key → fast blink, init done → slow blink" LED logic in the board test top.
- Drives N_CH LEDs from per-channel debounced keys, done levels and latched error codes.
- Error codes are shown as countable blink bursts.
- All blink phases derive from one shared tick, so every channel in the same mode blinks in lock-step.
- Sits in the board test top between peripheral self-test blocks (TF, SDRAM, ...) and the board LEDs/keys.

---
 rtl/test_led_pkg.sv | 31 +++
 rtl/key_debounce.sv | 62 ++++++
 rtl/test_status_led.sv | 226 ++++++++++++++++++++++
 tb/tb_test_status_led.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_led_pkg.sv
// Shared types and defaults for the board-test status LED block.
// Holds the code-burst FSM state type, default timing constants and a
// counter-width helper used to size every tick/phase/burst counter.

package test_led_pkg;

    // Error-code burst sequencer states
    typedef enum logic [1:0] {
        C_GAP = 2'd0,
        C_ON  = 2'd1,
        C_OFF = 2'd2
    } code_state_e;

    // Default geometry and timing (ticks unless noted)
    localparam int N_CH_DEF      = 4;
    localparam int CODE_W_DEF    = 3;
    localparam int TICK_DIV_DEF  = 250000;   // clock cycles per tick: 100 Hz at 25 MHz
    localparam int DEB_TICKS_DEF = 2;
    localparam int FAST_HALF_DEF = 4;
    localparam int MID_HALF_DEF  = 25;
    localparam int SLOW_HALF_DEF = 50;
    localparam int CODE_ON_DEF   = 20;
    localparam int CODE_OFF_DEF  = 20;
    localparam int CODE_GAP_DEF  = 100;

    // Bits needed for a counter that holds 0..n-1 (never less than one bit)
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Purpose: synchronise one raw active-low key, debounce it on base ticks,
//          and pulse once per debounced press.
// Latency: 2 cycles of synchroniser, then DEB_TICKS stable ticks to flip.
// Backpressure: none; free-running, consumes the tick strobe only.
//
// Ports:
//   clk    - core clock
//   rst    - synchronous active-high reset
//   tick   - one-cycle base tick strobe
//   key_n  - raw active-low key, asynchronous to clk
//   level  - debounced state, 1 = pressed
//   press  - one-cycle pulse in the cycle level rises

module key_debounce
    import test_led_pkg::*;
#(
    parameter int DEB_TICKS = DEB_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int DW = cnt_w(DEB_TICKS);
    // Counter reaching DEB_TICKS after increment == counter at DEB_TICKS-1 now
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);

    logic [1:0]    sync;
    logic          raw_pressed;
    logic [DW-1:0] stable_cnt;

    assign raw_pressed = ~sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchroniser comes out of reset reading "released"
            sync       <= 2'b11;
            stable_cnt <= '0;
            level      <= 1'b0;
            press      <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (tick) begin
                if (raw_pressed == level) begin
                    stable_cnt <= '0;
                end else if (stable_cnt == DEB_LAST) begin
                    stable_cnt <= '0;
                    level      <= ~level;
                    // Only a 0->1 transition is a press
                    press      <= ~level;
                end else begin
                    stable_cnt <= stable_cnt + DW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/test_status_led.sv
// Purpose: per-channel board-test status LEDs: key-held fast blink, latched
//          error code as countable bursts, done slow blink, idle mid blink.
// Latency: o_led is registered, 1 cycle behind the selected phase.
// Backpressure: none; all timing advances on a shared free-running tick.
//
// Ports:
//   i_clk_25m   - single clock
//   i_rst       - synchronous active-high reset
//   i_key_n     - raw active-low keys (asynchronous), one per channel
//   i_done      - per-channel test-done level
//   i_err       - per-channel error flag
//   i_err_code  - error codes, channel k at [k*CODE_W +: CODE_W]
//   o_led       - LED drive, 1 = on
//   o_key_level - debounced key state, 1 = pressed
//   o_key_press - one-cycle pulse per debounced press
//   o_tick      - base tick strobe

module test_status_led
    import test_led_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int N_CH      = N_CH_DEF,
    parameter int CODE_W    = CODE_W_DEF,
    parameter int DEB_TICKS = DEB_TICKS_DEF,
    parameter int FAST_HALF = FAST_HALF_DEF,
    parameter int MID_HALF  = MID_HALF_DEF,
    parameter int SLOW_HALF = SLOW_HALF_DEF,
    parameter int CODE_ON   = CODE_ON_DEF,
    parameter int CODE_OFF  = CODE_OFF_DEF,
    parameter int CODE_GAP  = CODE_GAP_DEF
) (
    input  logic                     i_clk_25m,
    input  logic                     i_rst,
    input  logic [N_CH-1:0]          i_key_n,
    input  logic [N_CH-1:0]          i_done,
    input  logic [N_CH-1:0]          i_err,
    input  logic [N_CH*CODE_W-1:0]   i_err_code,
    output logic [N_CH-1:0]          o_led,
    output logic [N_CH-1:0]          o_key_level,
    output logic [N_CH-1:0]          o_key_press,
    output logic                     o_tick
);

    // ------------------------------------------------------------------
    // Base tick
    // ------------------------------------------------------------------
    localparam int TW = cnt_w(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    // Decoded straight from the counter so the tick is seen in the same
    // cycle the counter sits at its last value
    assign tick   = (tick_cnt == TICK_LAST);
    assign o_tick = tick;

    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Shared blink phases; one set for all channels keeps LEDs in step
    // ------------------------------------------------------------------
    localparam int FW = cnt_w(FAST_HALF);
    localparam int MW = cnt_w(MID_HALF);
    localparam int SW = cnt_w(SLOW_HALF);
    localparam logic [FW-1:0] FAST_LAST = FW'(FAST_HALF - 1);
    localparam logic [MW-1:0] MID_LAST  = MW'(MID_HALF - 1);
    localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_HALF - 1);

    logic [FW-1:0] fast_cnt;
    logic [MW-1:0] mid_cnt;
    logic [SW-1:0] slow_cnt;
    logic          fast_ph;
    logic          mid_ph;
    logic          slow_ph;

    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            fast_cnt <= '0;
            mid_cnt  <= '0;
            slow_cnt <= '0;
            fast_ph  <= 1'b0;
            mid_ph   <= 1'b0;
            slow_ph  <= 1'b0;
        end else if (tick) begin
            if (fast_cnt == FAST_LAST) begin
                fast_cnt <= '0;
                fast_ph  <= ~fast_ph;
            end else begin
                fast_cnt <= fast_cnt + FW'(1);
            end

            if (mid_cnt == MID_LAST) begin
                mid_cnt <= '0;
                mid_ph  <= ~mid_ph;
            end else begin
                mid_cnt <= mid_cnt + MW'(1);
            end

            if (slow_cnt == SLOW_LAST) begin
                slow_cnt <= '0;
                slow_ph  <= ~slow_ph;
            end else begin
                slow_cnt <= slow_cnt + SW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel key, error latch and code burst sequencer
    // ------------------------------------------------------------------
    localparam int CODE_MAX_A = (CODE_GAP > CODE_ON) ? CODE_GAP : CODE_ON;
    localparam int CODE_MAX   = (CODE_MAX_A > CODE_OFF) ? CODE_MAX_A : CODE_OFF;
    localparam int CDW        = cnt_w(CODE_MAX);
    localparam logic [CDW-1:0] GAP_LAST = CDW'(CODE_GAP - 1);
    localparam logic [CDW-1:0] ON_LAST  = CDW'(CODE_ON - 1);
    localparam logic [CDW-1:0] OFF_LAST = CDW'(CODE_OFF - 1);

    logic [N_CH-1:0] led_sel;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic              err_lat;
        logic [CODE_W-1:0] code_lat;
        code_state_e       state;
        logic [CDW-1:0]    cnt;
        logic [CODE_W-1:0] pulse_cnt;
        logic              code_led;

        key_debounce #(
            .DEB_TICKS (DEB_TICKS)
        ) u_deb (
            .clk   (i_clk_25m),
            .rst   (i_rst),
            .tick  (tick),
            .key_n (i_key_n[k]),
            .level (o_key_level[k]),
            .press (o_key_press[k])
        );

        // First error wins and is frozen; a debounced press acknowledges it.
        // Clear has priority, so a still-high i_err re-latches a cycle later.
        always_ff @(posedge i_clk_25m) begin
            if (i_rst) begin
                err_lat  <= 1'b0;
                code_lat <= '0;
            end else if (o_key_press[k]) begin
                err_lat  <= 1'b0;
            end else if (!err_lat && i_err[k]) begin
                err_lat  <= 1'b1;
                code_lat <= i_err_code[k*CODE_W +: CODE_W];
            end
        end

        // Burst: long gap, then code_lat on-pulses separated by short offs.
        // Code 0 has no countable form and is shown steady on instead.
        always_ff @(posedge i_clk_25m) begin
            if (i_rst || !err_lat) begin
                state     <= C_GAP;
                cnt       <= '0;
                pulse_cnt <= '0;
            end else if (tick && (code_lat != '0)) begin
                case (state)
                    C_GAP: begin
                        if (cnt == GAP_LAST) begin
                            state     <= C_ON;
                            cnt       <= '0;
                            pulse_cnt <= '0;
                        end else begin
                            cnt <= cnt + CDW'(1);
                        end
                    end
                    C_ON: begin
                        if (cnt == ON_LAST) begin
                            state     <= C_OFF;
                            cnt       <= '0;
                            pulse_cnt <= pulse_cnt + CODE_W'(1);
                        end else begin
                            cnt <= cnt + CDW'(1);
                        end
                    end
                    C_OFF: begin
                        // After the last pulse the off slot folds straight into the gap
                        if (pulse_cnt == code_lat) begin
                            state <= C_GAP;
                            cnt   <= '0;
                        end else if (cnt == OFF_LAST) begin
                            state <= C_ON;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CDW'(1);
                        end
                    end
                    default: begin
                        state <= C_GAP;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign code_led = (code_lat == '0) ? 1'b1 : (state == C_ON);

        // Key feedback outranks error display, which outranks done/idle
        assign led_sel[k] = o_key_level[k] ? fast_ph  :
                            err_lat        ? code_led :
                            i_done[k]      ? slow_ph  :
                                             mid_ph;
    end

    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            o_led <= '0;
        end else begin
            o_led <= led_sel;
        end
    end

endmodule

// File: tb/tb_test_status_led.sv
module tb_test_status_led;

    localparam int N    = 4;
    localparam int CW   = 3;
    localparam int TD   = 4;
    localparam int DEB  = 2;
    localparam int FH   = 1;
    localparam int MH   = 2;
    localparam int SH   = 3;
    localparam int CON  = 1;
    localparam int COFF = 1;
    localparam int CGAP = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    key_n = '1;
    logic [N-1:0]    done = '0;
    logic [N-1:0]    err = '0;
    logic [N*CW-1:0] code = '0;
    logic [N-1:0]    led, lvl, prs;
    logic            tick;

    always #5 clk = ~clk;

    test_status_led #(
        .TICK_DIV(TD), .N_CH(N), .CODE_W(CW), .DEB_TICKS(DEB),
        .FAST_HALF(FH), .MID_HALF(MH), .SLOW_HALF(SH),
        .CODE_ON(CON), .CODE_OFF(COFF), .CODE_GAP(CGAP)
    ) dut (
        .i_clk_25m   (clk),
        .i_rst       (rst),
        .i_key_n     (key_n),
        .i_done      (done),
        .i_err       (err),
        .i_err_code  (code),
        .o_led       (led),
        .o_key_level (lvl),
        .o_key_press (prs),
        .o_tick      (tick)
    );

    int errors = 0;
    int checks = 0;
    int cur    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cur, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Time is tracked as edges since reset (m_n) and ticks consumed (m_T);
    // phases and burst position are derived arithmetically from these.
    int           m_n, m_T;
    bit [N-1:0]   m_lvl, m_prs, m_led, m_lat, m_d1, m_d2;
    int           m_code [N];
    int           m_latT [N];
    bit           m_samp [N][DEB];

    function automatic bit code_on(input int t, input int c);
        int per, p, q;
        if (c == 0) return 1'b1;
        per = CGAP + c*CON + (c-1)*COFF + 1;
        p = t % per;
        q = p - CGAP;
        return (p >= CGAP) && (q < c*(CON+COFF)) && ((q % (CON+COFF)) < CON);
    endfunction

    task automatic model_reset();
        m_n = 0; m_T = 0;
        m_lvl = '0; m_prs = '0; m_led = '0; m_lat = '0;
        m_d1 = '1; m_d2 = '1;
        for (int k = 0; k < N; k++) begin
            m_code[k] = 0; m_latT[k] = 0;
            for (int j = 0; j < DEB; j++) m_samp[k][j] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit tk, ph, all_diff;
        bit [N-1:0] nled, nprs;
        if (rst) begin
            model_reset();
            return;
        end
        tk = (m_n % TD) == TD-1;
        for (int k = 0; k < N; k++) begin
            if (m_lvl[k])      ph = ((m_T / FH) % 2) == 1;
            else if (m_lat[k]) ph = code_on(m_T - m_latT[k], m_code[k]);
            else if (done[k])  ph = ((m_T / SH) % 2) == 1;
            else               ph = ((m_T / MH) % 2) == 1;
            nled[k] = ph;
        end
        nprs = '0;
        if (tk) begin
            for (int k = 0; k < N; k++) begin
                for (int j = DEB-1; j > 0; j--) m_samp[k][j] = m_samp[k][j-1];
                m_samp[k][0] = ~m_d2[k];
                // level follows once the last DEB tick samples all disagree with it
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++) if (m_samp[k][j] == m_lvl[k]) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[k] = ~m_lvl[k];
                    nprs[k]  = m_lvl[k];
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (m_prs[k]) m_lat[k] = 1'b0;
            else if (!m_lat[k] && err[k]) begin
                m_lat[k]  = 1'b1;
                m_code[k] = int'(code[k*CW +: CW]);
                m_latT[k] = m_T + int'(tk);
            end
        end
        m_prs = nprs;
        m_led = nled;
        m_d2  = m_d1;
        m_d1  = key_n;
        m_n++;
        m_T  += int'(tk);
    endtask

    task automatic step();
        bit etk;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cur++;
        etk = (m_n % TD) == TD-1;
        check("model", {led, lvl, prs, tick}, {m_led, m_lvl, m_prs, etk});
    endtask

    // ---------------- idle vector table ----------------
    typedef struct {
        int           cyc;
        logic         tk;
        logic [N-1:0] led;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int cnt0, cnt1, cnt2, diff01, pcnt, oncnt, first;
        logic p0, p1, p2;
        int key_left [N];

        tbl.push_back('{1,  1'b0, 4'h0});
        tbl.push_back('{3,  1'b0, 4'h0});
        tbl.push_back('{4,  1'b1, 4'h0});
        tbl.push_back('{8,  1'b1, 4'h0});
        tbl.push_back('{9,  1'b0, 4'h0});
        tbl.push_back('{10, 1'b0, 4'hF});
        tbl.push_back('{12, 1'b1, 4'hF});
        tbl.push_back('{17, 1'b0, 4'hF});
        tbl.push_back('{18, 1'b0, 4'h0});
        tbl.push_back('{25, 1'b0, 4'h0});
        tbl.push_back('{26, 1'b0, 4'hF});

        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("reset_state", {led, lvl, prs, tick}, 32'd0);
        rst = 1'b0;
        cur = 1;

        // Idle blink and tick timing from the table
        for (int i = 0; i < tbl.size(); i++) begin
            for (int g = 0; g < 100 && cur < tbl[i].cyc; g++) step();
            check("tbl_tick", tick, tbl[i].tk);
            check("tbl_led",  led,  tbl[i].led);
        end

        // Done on channels 0,1: slow blink in phase; 2,3 stay idle
        done = 4'b0011;
        for (int i = 0; i < 4; i++) step();
        cnt0 = 0; cnt1 = 0; cnt2 = 0; diff01 = 0;
        p0 = led[0]; p1 = led[1]; p2 = led[2];
        for (int i = 0; i < 48; i++) begin
            step();
            if (led[0] != p0) cnt0++;
            if (led[1] != p1) cnt1++;
            if (led[2] != p2) cnt2++;
            if (led[0] != led[1]) diff01++;
            p0 = led[0]; p1 = led[1]; p2 = led[2];
        end
        check("done_ch0_toggles", cnt0, 4);
        check("done_ch1_toggles", cnt1, 4);
        check("done_ch01_phase", diff01, 0);
        check("idle_ch2_toggles", cnt2, 6);
        done = '0;

        // One-tick glitch on key 2 is swallowed
        for (int i = 0; i < 4; i++) step();
        pcnt = 0;
        key_n[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin step(); pcnt += int'(prs[2]); end
        key_n[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin step(); pcnt += int'(prs[2]); end
        check("glitch_press", pcnt, 0);
        check("glitch_level", lvl[2], 1'b0);

        // Long hold: exactly one press, fast blink while held
        pcnt = 0;
        key_n[2] = 1'b0;
        for (int i = 0; i < 24; i++) begin step(); pcnt += int'(prs[2]); end
        check("hold_press", pcnt, 1);
        check("hold_level", lvl[2], 1'b1);
        cnt2 = 0; p2 = led[2];
        for (int i = 0; i < 16; i++) begin
            step();
            if (led[2] != p2) cnt2++;
            p2 = led[2];
        end
        check("hold_fast_toggles", cnt2, 4);
        key_n[2] = 1'b1;
        pcnt = 0;
        for (int i = 0; i < 24; i++) begin step(); pcnt += int'(prs[2]); end
        check("release_press", pcnt, 0);
        check("release_level", lvl[2], 1'b0);
        cnt2 = 0; p2 = led[2];
        for (int i = 0; i < 32; i++) begin
            step();
            if (led[2] != p2) cnt2++;
            p2 = led[2];
        end
        check("release_idle_toggles", cnt2, 4);

        // Error code 3 on channel 1, later code changes ignored
        err[1] = 1'b1;
        code[5:3] = 3'd3;
        step();
        err[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            code = N*CW'($urandom);
            step();
        end
        oncnt = 0;
        for (int i = 0; i < 72; i++) begin
            code = N*CW'($urandom);
            step();
            oncnt += int'(led[1]);
        end
        check("code3_on_cycles", oncnt, 24);

        // Error code 0 on channel 0 is steady on
        code = '0;
        err[0] = 1'b1;
        step();
        err[0] = 1'b0;
        for (int i = 0; i < 2; i++) step();
        oncnt = 0;
        for (int i = 0; i < 40; i++) begin step(); oncnt += int'(led[0]); end
        check("code0_steady", oncnt, 40);

        // Press on ch0 with i_err low clears it back to idle blink
        key_n[0] = 1'b0;
        for (int i = 0; i < 24; i++) step();
        key_n[0] = 1'b1;
        for (int i = 0; i < 24; i++) step();
        oncnt = 0;
        for (int i = 0; i < 32; i++) begin step(); oncnt += int'(led[0]); end
        check("clear_idle_on_cycles", oncnt, 16);

        // Press with i_err held high: latch recaptures and shows steady on again
        err[0] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        key_n[0] = 1'b0;
        for (int i = 0; i < 24; i++) step();
        key_n[0] = 1'b1;
        for (int i = 0; i < 24; i++) step();
        oncnt = 0;
        for (int i = 0; i < 40; i++) begin step(); oncnt += int'(led[0]); end
        check("recapture_steady", oncnt, 40);
        err[0] = 1'b0;

        // Mid-burst reset (ch1 still bursting)
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        check("midrst_outputs", {led, lvl, prs, tick}, 32'd0);
        rst = 1'b0;
        first = -1;
        for (int i = 1; i <= 20 && first < 0; i++) begin
            step();
            if (tick) first = i + 1;
        end
        check("midrst_first_tick_cycle", first, TD);

        // Randomised traffic against the model
        for (int k = 0; k < N; k++) key_left[k] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (key_left[k] == 0) begin
                    key_n[k]    = ($urandom_range(0, 9) < 7);
                    key_left[k] = $urandom_range(1, 40);
                end else begin
                    key_left[k]--;
                end
                err[k] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 31) == 0) done[k] = ~done[k];
            end
            code = N*CW'($urandom);
            rst  = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
